// File: rtl/div_32.sv
// Sequential 32-bit non-restoring divider: one quotient bit per clock, remainder fix-up, one-cycle done.
// Define DIV_32_SIGNED_EN for signed two's-complement operands; otherwise operands are unsigned.
module div_32 #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  typedef enum logic [1:0] {IDLE, ITER, FIX, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH:0]   rem_q, rem_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [4:0]       count_q, count_d;
  logic             dz_q, dz_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             done_q, done_d;
  logic             div_by_zero_q, div_by_zero_d;
`ifdef DIV_32_SIGNED_EN
  logic             qneg_q, qneg_d;
  logic             rneg_q, rneg_d;
`endif

  logic [WIDTH:0]   rem_shift;
  logic [WIDTH:0]   rem_step;
  logic [WIDTH:0]   rem_fix;
  logic [WIDTH-1:0] mag_dvd;
  logic [WIDTH-1:0] mag_dvs;

  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign done        = done_q;
  assign div_by_zero = div_by_zero_q;
  // Still busy in the done cycle so a start there is dropped.
  assign busy        = (state_q != IDLE) || done_q;

  always_comb begin
    state_d       = state_q;
    rem_d         = rem_q;
    q_d           = q_q;
    dvs_d         = dvs_q;
    count_d       = count_q;
    dz_d          = dz_q;
    quotient_d    = quotient_q;
    remainder_d   = remainder_q;
    done_d        = 1'b0;
    div_by_zero_d = div_by_zero_q;
`ifdef DIV_32_SIGNED_EN
    qneg_d        = qneg_q;
    rneg_d        = rneg_q;
    mag_dvd       = dividend[WIDTH-1] ? -dividend : dividend;
    mag_dvs       = divisor[WIDTH-1]  ? -divisor  : divisor;
`else
    mag_dvd       = dividend;
    mag_dvs       = divisor;
`endif

    // {rem,q} shifted left by one; rem keeps 33 bits, arithmetic wraps mod 2^33.
    rem_shift = {rem_q[WIDTH-1:0], q_q[WIDTH-1]};
    rem_step  = rem_q[WIDTH] ? (rem_shift + {1'b0, dvs_q}) : (rem_shift - {1'b0, dvs_q});
    rem_fix   = rem_q[WIDTH] ? (rem_q + {1'b0, dvs_q}) : rem_q;

    case (state_q)
      IDLE: begin
        if (start && !done_q) begin
          div_by_zero_d = 1'b0;
          count_d       = 5'd0;
          if (divisor == '0) begin
            state_d = DONE;
            q_d     = '1;
            rem_d   = {1'b0, dividend};
            dz_d    = 1'b1;
          end else begin
            state_d = ITER;
            rem_d   = '0;
            q_d     = mag_dvd;
            dvs_d   = mag_dvs;
            dz_d    = 1'b0;
`ifdef DIV_32_SIGNED_EN
            qneg_d  = dividend[WIDTH-1] ^ divisor[WIDTH-1];
            rneg_d  = dividend[WIDTH-1];
`endif
          end
        end
      end
      ITER: begin
        rem_d   = rem_step;
        q_d     = {q_q[WIDTH-2:0], ~rem_step[WIDTH]};
        count_d = count_q + 5'd1;
        if (count_q == 5'd31) begin
          state_d = FIX;
        end
      end
      FIX: begin
`ifdef DIV_32_SIGNED_EN
        rem_d = rneg_q ? -rem_fix : rem_fix;
        q_d   = qneg_q ? -q_q : q_q;
`else
        rem_d = rem_fix;
`endif
        state_d = DONE;
      end
      DONE: begin
        quotient_d    = q_q;
        remainder_d   = rem_q[WIDTH-1:0];
        done_d        = 1'b1;
        div_by_zero_d = dz_q;
        state_d       = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_q       <= IDLE;
      rem_q         <= '0;
      q_q           <= '0;
      dvs_q         <= '0;
      count_q       <= 5'd0;
      dz_q          <= 1'b0;
      quotient_q    <= '0;
      remainder_q   <= '0;
      done_q        <= 1'b0;
      div_by_zero_q <= 1'b0;
`ifdef DIV_32_SIGNED_EN
      qneg_q        <= 1'b0;
      rneg_q        <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      rem_q         <= rem_d;
      q_q           <= q_d;
      dvs_q         <= dvs_d;
      count_q       <= count_d;
      dz_q          <= dz_d;
      quotient_q    <= quotient_d;
      remainder_q   <= remainder_d;
      done_q        <= done_d;
      div_by_zero_q <= div_by_zero_d;
`ifdef DIV_32_SIGNED_EN
      qneg_q        <= qneg_d;
      rneg_q        <= rneg_d;
`endif
    end
  end

endmodule
